// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: widths, state encoding and buffer entry.
// Imported by fetch_buf and instr_fetch_unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Circular fetch buffer: entries are reserved at request time,
// filled in order by responses and popped from the head.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            reserve_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            pop_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic [CW-1:0]   count_o
);

  entry_t        ent_q [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] fill_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] cnt_q;

  // Flush only drops occupancy; payload is kept so the head
  // outputs do not glitch while if_valid is low.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].filled <= 1'b0;
        if (rst) begin
          ent_q[i].pc    <= '0;
          ent_q[i].instr <= '0;
        end
      end
    end else begin
      if (pop_i) begin
        ent_q[head_q].filled <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      if (reserve_i) begin
        ent_q[tail_q].pc     <= pc_i;
        ent_q[tail_q].filled <= 1'b0;
        tail_q <= tail_q + 1'b1;
      end
      if (fill_i) begin
        ent_q[fill_q].instr  <= instr_i;
        ent_q[fill_q].filled <= 1'b1;
        fill_q <= fill_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(fill_i) - CW'(pop_i);
    end
  end

  assign valid_o = ent_q[head_q].filled;
  assign pc_o    = ent_q[head_q].pc;
  assign instr_o = ent_q[head_q].instr;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, request issue, redirect flush and drain.
// FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            misalign_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   buf_cnt;
  logic [CW:0]     occ;
  logic            fault_q;
  logic            acc, pop, buf_valid;
  logic            rsp_drop, rsp_take, rsp_fill;

  // Occupancy counts the slot freed by a same-cycle pop so that
  // a single-cycle memory sustains one instruction per cycle.
  assign occ = {1'b0, out_q} + {1'b0, buf_cnt}
             - {{CW{1'b0}}, pop};

  assign imem_req_valid = !rst && state_q == FETCH && !fault_q
                        && occ < (CW+1)'(DEPTH);
  assign imem_addr = pc_q;
  assign acc       = imem_req_valid && imem_req_ready;
  assign if_valid  = buf_valid && !fault_q;
  assign pop       = if_valid && if_ready;

  assign rsp_drop = imem_rsp_valid && drop_q != '0;
  assign rsp_take = imem_rsp_valid && drop_q == '0 && out_q != '0;
  assign rsp_fill = rsp_take && !redirect_valid;

  always_comb begin
    drop_d = drop_q - CW'(rsp_drop);
    out_d  = out_q + CW'(acc) - CW'(rsp_take);
    if (redirect_valid) begin
      drop_d = drop_d + out_d;
      out_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= (drop_d != '0) ? DRAIN : FETCH;
      out_q   <= out_d;
      drop_q  <= drop_d;
      if (redirect_valid)
        pc_q <= word_align(redirect_pc);
      else if (acc)
        pc_q <= pc_q + XLEN'(4);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)
      fault_q <= 1'b0;
    else if (redirect_valid)
      fault_q <= |redirect_pc[1:0];
  end
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  assign fault_q   = 1'b0;
`endif

  assign misalign_fault = fault_q;

  fetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (redirect_valid),
    .reserve_i(acc && !redirect_valid),
    .pc_i     (pc_q),
    .fill_i   (rsp_fill),
    .instr_i  (imem_rsp_data),
    .pop_i    (pop),
    .valid_o  (buf_valid),
    .pc_o     (if_pc),
    .instr_o  (if_instr),
    .count_o  (buf_cnt)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order latency memory
// model plus a delivered-PC-stream reference model.
module tb_instr_fetch_unit;

  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_addr, imem_rsp_data;
  logic            imem_rsp_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid, if_ready;
  logic [XLEN-1:0] if_instr, if_pc;
  logic            misalign_fault;

  instr_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc, lat, rdy_pct, ifr_pct;
  int n_acc, n_pop, first_valid;
  logic [XLEN-1:0] q_addr[$];
  int              q_due[$];
  logic [XLEN-1:0] exp_pc, exp_req, last_pop_pc;
  logic [XLEN-1:0] last_acc_addr, wrap_addr;
  logic [XLEN-1:0] hold_pc, hold_instr;
  logic            hold, prev_redir;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_fault", 32'(misalign_fault), 32'd0);
    q_addr.delete();
    q_due.delete();
    exp_pc = RESET_PC;
    exp_req = RESET_PC;
    hold = 1'b0;
    prev_redir = 1'b0;
    cyc = 0;
    n_acc = 0;
    n_pop = 0;
    first_valid = -1;
    last_acc_addr = '0;
    rst = 1'b0;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input logic redir, input logic [XLEN-1:0] tgt);
    logic acc, pop, rv;
    if (first_valid < 0 && if_valid) first_valid = cyc;
    if (prev_redir)
      chk("flush_if_valid", 32'(if_valid), 32'd0);
    if (hold) begin
      chk("hold_valid", 32'(if_valid), 32'd1);
      chk("hold_pc", if_pc, hold_pc);
      chk("hold_instr", if_instr, hold_instr);
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    rv = q_due.size() != 0 && q_due[0] <= cyc;
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? mem_word(q_addr[0]) : '0;
    if_ready = ($urandom_range(99) < ifr_pct);
    redirect_valid = redir;
    redirect_pc = tgt;
    #1;
    acc = imem_req_valid && imem_req_ready;
    pop = if_valid && if_ready;
    if (acc) begin
      chk("req_addr", imem_addr, exp_req);
      if (last_acc_addr == 32'hFFFF_FFFC) wrap_addr = imem_addr;
      last_acc_addr = imem_addr;
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
      exp_req = exp_req + 32'd4;
      n_acc++;
    end
    if (pop) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, mem_word(exp_pc));
      last_pop_pc = if_pc;
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (redir) begin
      exp_pc = {tgt[XLEN-1:2], 2'b00};
      exp_req = {tgt[XLEN-1:2], 2'b00};
    end
    hold = if_valid && !pop && !redir;
    hold_pc = if_pc;
    hold_instr = if_instr;
    prev_redir = redir;
    @(posedge clk);
    if (rv) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    cyc++;
    @(negedge clk);
    chk("mem_outstanding", 32'(q_addr.size() <= DEPTH), 32'd1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pop(input string tag, input int budget);
    int n0;
    n0 = n_pop;
    for (int i = 0; i < budget; i++) begin
      if (n_pop != n0) break;
      step(1'b0, '0);
    end
    chk(tag, 32'(n_pop != n0), 32'd1);
  endtask

  initial begin
    int a0;
    lat = 1;
    rdy_pct = 100;
    ifr_pct = 100;
    do_reset();

    repeat (20) step(1'b0, '0);
    chk("startup_cycle", 32'(first_valid), 32'd2);
    chk("throughput", 32'(n_pop), 32'd18);

    ifr_pct = 0;
    repeat (5) begin
      step(1'b0, '0);
      chk("stall_bound", 32'(n_acc - n_pop <= DEPTH), 32'd1);
    end
    chk("stall_full", 32'(n_acc - n_pop), 32'(DEPTH));
    ifr_pct = 100;
    repeat (10) step(1'b0, '0);

    lat = 3;
    repeat (10) step(1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      if (q_addr.size() == 2) break;
      step(1'b0, '0);
    end
    chk("two_inflight", 32'(q_addr.size()), 32'd2);
    step(1'b1, 32'h100);
    wait_pop("redir_wait", 30);
    chk("redir_target", last_pop_pc, 32'h100);

    lat = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (if_valid && if_pc == 32'h8) break;
      step(1'b0, '0);
    end
    chk("coinc_at8", if_pc, 32'h8);
    step(1'b1, 32'h40);
    chk("coinc_delivered", last_pop_pc, 32'h8);
    wait_pop("coinc_wait", 20);
    chk("coinc_next", last_pop_pc, 32'h40);

    wrap_addr = 32'hDEAD_BEEF;
    step(1'b1, 32'hFFFF_FFF8);
    repeat (10) step(1'b0, '0);
    chk("wrap_addr", wrap_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHK_EN
    step(1'b1, 32'h102);
    a0 = n_acc;
    repeat (5) step(1'b0, '0);
    chk("fault_set", 32'(misalign_fault), 32'd1);
    chk("fault_noreq", 32'(n_acc - a0), 32'd0);
    chk("fault_if_valid", 32'(if_valid), 32'd0);
    step(1'b1, 32'h200);
    chk("fault_clear", 32'(misalign_fault), 32'd0);
    wait_pop("fault_resume", 20);
    chk("fault_resume_pc", last_pop_pc, 32'h200);
`else
    a0 = n_acc;
    step(1'b1, 32'h102);
    chk("nofault", 32'(misalign_fault), 32'd0);
    wait_pop("mask_wait", 20);
    chk("mask_pc", last_pop_pc, 32'h100);
    chk("mask_progress", 32'(n_acc > a0), 32'd1);
`endif

    rdy_pct = 60;
    ifr_pct = 70;
    for (int i = 0; i < 500; i++) begin
      if (i % 50 == 0) lat = $urandom_range(4, 1);
      step($urandom_range(99) < 4, $urandom & 32'hFFFF_FFFC);
    end
    rdy_pct = 100;
    ifr_pct = 100;
    wait_pop("final_wait", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
